// File: rtl/regfile_sequencer_if.sv
// Bundle between the sequencer and its neighbours: the instruction handshake,
// the register file port, the OUT result handshake and the status outputs.
interface regfile_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       reg_en;
  logic       reg_rw;
  logic [1:0] reg_sel;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flag_z;
  logic       flag_c;
  logic       err;

  modport master (
    output instr_valid, instr, imm, reg_rdata, out_ready,
    input  instr_ready, reg_en, reg_rw, reg_sel, reg_wdata,
           out_valid, out_data, flag_z, flag_c, err
  );

  modport slave (
    input  instr_valid, instr, imm, reg_rdata, out_ready,
    output instr_ready, reg_en, reg_rw, reg_sel, reg_wdata,
           out_valid, out_data, flag_z, flag_c, err
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Instruction sequencer for a 4x8 register file: walks each decoded instruction
// through read / execute / write-back phases with an 8-bit add/sub unit.
module regfile_sequencer (
  input  logic               clk,
  input  logic               rst,
  regfile_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_EXEC, S_WR, S_OUTP
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LDI = 3'd1, OP_MOV = 3'd2,
                         OP_ADD = 3'd3, OP_SUB = 3'd4, OP_OUT = 3'd5;

  state_t     state_q, state_d;
  logic [6:0] ins_q, ins_d;      // {opcode, rd, rs}; instr[4] is dropped
  logic [7:0] imm_q, imm_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [7:0] res_q, res_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic       err_q, err_d;

  logic       reg_en, reg_rw;
  logic [1:0] reg_sel;
  logic [7:0] reg_wdata;
  logic       instr_ready;

  logic [2:0] op;
  logic [1:0] rd, rs;
  logic       is_alu;
  logic [8:0] sum9;

  assign op     = ins_q[6:4];
  assign rd     = ins_q[3:2];
  assign rs     = ins_q[1:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
  assign sum9   = {1'b0, opa_q} + {1'b0, opb_q};

  assign instr_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    err_d     = 1'b0;
    reg_en    = 1'b0;
    reg_rw    = 1'b0;
    reg_sel   = 2'd0;
    reg_wdata = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && instr_ready) begin
          ins_d = {bus.instr[7:5], bus.instr[3:0]};
          imm_d = bus.imm;
          case (bus.instr[7:5])
            OP_NOP:                         state_d = S_IDLE;
            OP_LDI:                         state_d = S_WR;
            OP_MOV, OP_ADD, OP_SUB, OP_OUT: state_d = S_RD_A;
            default:                        err_d   = 1'b1;
          endcase
        end
      end
      S_RD_A: begin
        reg_en  = 1'b1;
        reg_rw  = 1'b1;
        reg_sel = is_alu ? rd : rs;
        state_d = is_alu ? S_RD_B : S_CAP_B;
      end
      S_RD_B: begin
        reg_en  = 1'b1;
        reg_rw  = 1'b1;
        reg_sel = rs;
        opa_d   = bus.reg_rdata;
        state_d = S_CAP_B;
      end
      S_CAP_B: begin
        // Read data here answers the request made in the previous cycle.
        if (is_alu) begin
          opb_d   = bus.reg_rdata;
          state_d = S_EXEC;
        end else begin
          opa_d   = bus.reg_rdata;
          state_d = (op == OP_MOV) ? S_WR : S_OUTP;
        end
      end
      S_EXEC: begin
        res_d   = (op == OP_SUB) ? (opa_q - opb_q) : sum9[7:0];
        state_d = S_WR;
      end
      S_WR: begin
        reg_en  = 1'b1;
        reg_rw  = 1'b0;
        reg_sel = rd;
        case (op)
          OP_LDI:  reg_wdata = imm_q;
          OP_MOV:  reg_wdata = opa_q;
          default: reg_wdata = res_q;
        endcase
        if (is_alu) begin
          flag_z_d = (res_q == 8'd0);
          flag_c_d = (op == OP_SUB) ? (opa_q < opb_q) : sum9[8];
        end
        state_d = S_IDLE;
      end
      S_OUTP: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ins_q    <= 7'd0;
      imm_q    <= 8'd0;
      opa_q    <= 8'd0;
      opb_q    <= 8'd0;
      res_q    <= 8'd0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ins_q    <= ins_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      err_q    <= err_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.reg_en      = reg_en;
  assign bus.reg_rw      = reg_rw;
  assign bus.reg_sel     = reg_sel;
  assign bus.reg_wdata   = reg_wdata;
  assign bus.out_valid   = (state_q == S_OUTP);
  assign bus.out_data    = opa_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a 1-cycle-latency register file model.
module tb_regfile_sequencer;
  logic clk = 1'b0;
  logic rst;
  regfile_sequencer_if bus ();

  regfile_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LDI = 3'd1, OP_MOV = 3'd2,
                         OP_ADD = 3'd3, OP_SUB = 3'd4, OP_OUT = 3'd5, OP_BAD = 3'd7;

  logic [7:0] mem [4];
  int wr_cnt  = 0;
  int acc_cnt = 0;
  int n_cmp   = 0;
  int n_err   = 0;

  always @(posedge clk) begin
    if (bus.reg_en) begin
      acc_cnt <= acc_cnt + 1;
      if (bus.reg_rw) bus.reg_rdata <= mem[bus.reg_sel];
      else begin
        mem[bus.reg_sel] <= bus.reg_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [7:0] im);
    chk("ready_before_send", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, 1'b0, rd, rs};
    bus.imm         = im;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (!bus.instr_ready && busy < 50) begin
      busy++;
      tick();
    end
    if (busy >= 50) chk("idle_timeout", 1, 0);
  endtask

  int busy, w0, a0;

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'd0;
    bus.imm         = 8'd0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_reg_en", bus.reg_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_c}, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.instr_ready, 1);

    // LDI r2,0x5A: single WR cycle
    send(OP_LDI, 2'd2, 2'd0, 8'h5A);
    chk("ldi_en", bus.reg_en, 1);
    chk("ldi_rw", bus.reg_rw, 0);
    chk("ldi_sel", bus.reg_sel, 2);
    chk("ldi_wdata", bus.reg_wdata, 8'h5A);
    wait_idle(busy);
    chk("ldi_busy", busy, 1);
    chk("ldi_mem", mem[2], 8'h5A);

    // 0xF0 + 0x20 = 0x110 -> 0x10 with carry
    send(OP_LDI, 2'd0, 2'd0, 8'hF0); wait_idle(busy);
    send(OP_LDI, 2'd1, 2'd0, 8'h20); wait_idle(busy);
    send(OP_ADD, 2'd0, 2'd1, 8'h00); wait_idle(busy);
    chk("add_busy", busy, 5);
    chk("add_mem", mem[0], 8'h10);
    chk("add_c", bus.flag_c, 1);
    chk("add_z", bus.flag_z, 0);

    send(OP_LDI, 2'd3, 2'd0, 8'h07); wait_idle(busy);
    send(OP_SUB, 2'd3, 2'd3, 8'h00); wait_idle(busy);
    chk("subself_busy", busy, 5);
    chk("subself_mem", mem[3], 8'h00);
    chk("subself_z", bus.flag_z, 1);
    chk("subself_c", bus.flag_c, 0);

    // 0x01 - 0x02 borrows
    send(OP_LDI, 2'd0, 2'd0, 8'h01); wait_idle(busy);
    send(OP_LDI, 2'd1, 2'd0, 8'h02); wait_idle(busy);
    send(OP_SUB, 2'd0, 2'd1, 8'h00); wait_idle(busy);
    chk("sub_mem", mem[0], 8'hFF);
    chk("sub_c", bus.flag_c, 1);
    chk("sub_z", bus.flag_z, 0);

    // ADD r1,r1 doubles r1 (0x02 -> 0x04), carry clear
    send(OP_ADD, 2'd1, 2'd1, 8'h00); wait_idle(busy);
    chk("dbl_mem", mem[1], 8'h04);
    chk("dbl_c", bus.flag_c, 0);
    // restore the borrow flags for the later unchanged-flag checks
    send(OP_SUB, 2'd0, 2'd1, 8'h00); wait_idle(busy);
    chk("sub2_mem", mem[0], 8'hFB);
    chk("sub2_c", bus.flag_c, 0);
    send(OP_SUB, 2'd1, 2'd0, 8'h00); wait_idle(busy);
    chk("sub3_mem", mem[1], 8'h09);
    chk("sub3_c", bus.flag_c, 1);

    send(OP_MOV, 2'd1, 2'd2, 8'h00); wait_idle(busy);
    chk("mov_busy", busy, 3);
    chk("mov_mem", mem[1], 8'h5A);

    // OUT r1 with out_ready low for 4 cycles
    send(OP_OUT, 2'd0, 2'd1, 8'h00);
    tick();
    chk("out_not_yet", bus.out_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, 8'h5A);
      chk("out_busy", bus.instr_ready, 0);
      if (i < 3) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_drop", bus.out_valid, 0);
    chk("out_ready_back", bus.instr_ready, 1);
    chk("out_flags", {bus.flag_z, bus.flag_c}, 2'b01);

    // illegal then NOP on consecutive edges
    w0 = wr_cnt;
    a0 = acc_cnt;
    chk("err_idle", bus.err, 0);
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_BAD, 5'd0};
    tick();
    chk("ill_err", bus.err, 1);
    chk("ill_ready", bus.instr_ready, 1);
    bus.instr = {OP_NOP, 5'd0};
    tick();
    bus.instr_valid = 1'b0;
    chk("nop_err", bus.err, 0);
    chk("nop_ready", bus.instr_ready, 1);
    tick();
    chk("nop_err2", bus.err, 0);
    chk("ill_no_access", acc_cnt - a0, 0);
    chk("ill_flags", {bus.flag_z, bus.flag_c}, 2'b01);

    // reset during EXEC of ADD r0,r1
    w0 = wr_cnt;
    send(OP_ADD, 2'd0, 2'd1, 8'h00);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_ready", bus.instr_ready, 0);
    chk("abort_en", bus.reg_en, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_flags", {bus.flag_z, bus.flag_c}, 0);
    chk("abort_err", bus.err, 0);
    tick(); tick();
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_mem", mem[0], 8'hFB);
    rst = 1'b0;
    #1;
    send(OP_LDI, 2'd3, 2'd0, 8'hA5); wait_idle(busy);
    chk("post_abort_busy", busy, 1);
    chk("post_abort_mem", mem[3], 8'hA5);
    chk("post_abort_flags", {bus.flag_z, bus.flag_c}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
